// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the coprocessor block-memory access controller:
// memory geometry, requester indices and controller state encodings.
package mem_ctrl_pkg;

  localparam int SIZE       = 1024;
  localparam int BLOCKS     = 4;
  localparam int LOG_SIZE   = 10;
  localparam int CELL_WIDTH = 32;
  localparam int WIDTH      = BLOCKS * CELL_WIDTH;

  localparam logic R_HOST   = 1'b0;
  localparam logic R_ENGINE = 1'b1;

  // Highest base address whose whole block still fits inside the memory.
  localparam logic [LOG_SIZE-1:0] ADDR_LIMIT = LOG_SIZE'(SIZE - BLOCKS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin arbiter; the caller owns and
// updates the registered last-grant index.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_valid_o = |req_i;
    gnt_idx_o   = R_HOST;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_idx_o = R_ENGINE;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single block-memory port between host and engine: round-robin
// grant, range check, one read/write enable pulse, req/ack handshake.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_r0_req,
  input  logic                in_r0_we,
  input  logic [LOG_SIZE-1:0] in_r0_address,
  input  logic [WIDTH-1:0]    in_r0_data,
  output logic                out_r0_ack,
  output logic                out_r0_err,
  output logic [WIDTH-1:0]    out_r0_data,
  input  logic                in_r1_req,
  input  logic                in_r1_we,
  input  logic [LOG_SIZE-1:0] in_r1_address,
  input  logic [WIDTH-1:0]    in_r1_data,
  output logic                out_r1_ack,
  output logic                out_r1_err,
  output logic [WIDTH-1:0]    out_r1_data,
  output logic [LOG_SIZE-1:0] out_mem_address,
  output logic [WIDTH-1:0]    out_mem_data,
  output logic                out_mem_read_en,
  output logic                out_mem_write_en,
  input  logic [WIDTH-1:0]    in_mem_data
);

  state_e              state_q;
  logic                gnt_q;
  logic                last_grant_q;
  logic                we_q;
  logic [LOG_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [1:0]          ack_q;
  logic [1:0]          err_q;
  logic [WIDTH-1:0]    rdata0_q;
  logic [WIDTH-1:0]    rdata1_q;
  logic [LOG_SIZE-1:0] mem_addr_q;
  logic [WIDTH-1:0]    mem_data_q;
  logic                rd_en_q;
  logic                wr_en_q;

  logic gnt_valid;
  logic gnt_idx;

  rr_arbiter2 u_arb (
    .req_i        ({in_r1_req, in_r0_req}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= IDLE;
      gnt_q        <= R_HOST;
      last_grant_q <= R_ENGINE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values; pulse outputs default low and are set per state.
      ack_q   <= '0;
      err_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q        <= gnt_idx;
            last_grant_q <= gnt_idx;
            we_q         <= gnt_idx ? in_r1_we      : in_r0_we;
            addr_q       <= gnt_idx ? in_r1_address : in_r0_address;
            wdata_q      <= gnt_idx ? in_r1_data    : in_r0_data;
            state_q      <= CHECK;
          end
        end
        CHECK: begin
          if (addr_q > ADDR_LIMIT) begin
            ack_q[gnt_q] <= 1'b1;
            err_q[gnt_q] <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_addr_q <= addr_q;
            mem_data_q <= wdata_q;
            rd_en_q    <= ~we_q;
            wr_en_q    <= we_q;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            ack_q[gnt_q] <= 1'b1;
            state_q      <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Memory read data is only meaningful in the cycle after the enable.
          if (gnt_q == R_ENGINE) rdata1_q <= in_mem_data;
          else                   rdata0_q <= in_mem_data;
          ack_q[gnt_q] <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_r0_ack       = ack_q[0];
  assign out_r0_err       = err_q[0];
  assign out_r0_data      = rdata0_q;
  assign out_r1_ack       = ack_q[1];
  assign out_r1_err       = err_q[1];
  assign out_r1_data      = rdata1_q;
  assign out_mem_address  = mem_addr_q;
  assign out_mem_data     = mem_data_q;
  assign out_mem_read_en  = rd_en_q;
  assign out_mem_write_en = wr_en_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed transactions push expected
// acks and memory operations; negedge monitors pop and compare.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                r0_req, r0_we, r0_ack, r0_err;
  logic [LOG_SIZE-1:0] r0_addr;
  logic [WIDTH-1:0]    r0_wdata, r0_rdata;
  logic                r1_req, r1_we, r1_ack, r1_err;
  logic [LOG_SIZE-1:0] r1_addr;
  logic [WIDTH-1:0]    r1_wdata, r1_rdata;
  logic [LOG_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata, mem_rdata;
  logic                mem_rd, mem_wr;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .in_clk           (clk),
    .in_reset         (rst_n),
    .in_r0_req        (r0_req),
    .in_r0_we         (r0_we),
    .in_r0_address    (r0_addr),
    .in_r0_data       (r0_wdata),
    .out_r0_ack       (r0_ack),
    .out_r0_err       (r0_err),
    .out_r0_data      (r0_rdata),
    .in_r1_req        (r1_req),
    .in_r1_we         (r1_we),
    .in_r1_address    (r1_addr),
    .in_r1_data       (r1_wdata),
    .out_r1_ack       (r1_ack),
    .out_r1_err       (r1_err),
    .out_r1_data      (r1_rdata),
    .out_mem_address  (mem_addr),
    .out_mem_data     (mem_wdata),
    .out_mem_read_en  (mem_rd),
    .out_mem_write_en (mem_wr),
    .in_mem_data      (mem_rdata)
  );

  // Block memory model: 32-bit cells, base cell in the low word, registered read.
  logic [31:0]      cells [SIZE];
  logic             rd_valid = 1'b0;
  logic [WIDTH-1:0] rd_buf = '0;

  initial for (int i = 0; i < SIZE; i++) cells[i] = 32'hC0DE_0000 | i;

  always @(posedge clk) begin
    rd_valid <= mem_rd;
    for (int k = 0; k < BLOCKS; k++) begin
      if (mem_wr) cells[(int'(mem_addr) + k) % SIZE] <= mem_wdata[k*CELL_WIDTH +: CELL_WIDTH];
      if (mem_rd) rd_buf[k*CELL_WIDTH +: CELL_WIDTH] <= cells[(int'(mem_addr) + k) % SIZE];
    end
  end

  assign mem_rdata = rd_valid ? rd_buf : {BLOCKS{32'hBAD0_BAD0}};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             rid;
    logic             err;
    logic             chk_data;
    logic [WIDTH-1:0] data;
    int               exp_cyc;
  } exp_t;

  typedef struct {
    logic                we;
    logic [LOG_SIZE-1:0] addr;
    logic [WIDTH-1:0]    data;
  } mop_t;

  exp_t sb_q[$];
  mop_t mop_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r0_ack && r1_ack) fail_now("double_ack");
      else if (r0_ack || r1_ack) begin
        if (sb_q.size() == 0) fail_now("unexpected_ack");
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ack_requester", WIDTH'(r1_ack), WIDTH'(e.rid));
          check("ack_err", WIDTH'(e.rid ? r1_err : r0_err), WIDTH'(e.err));
          if (e.chk_data) check("read_data", e.rid ? r1_rdata : r0_rdata, e.data);
          if (e.exp_cyc >= 0) check("ack_latency", WIDTH'(cyc), WIDTH'(e.exp_cyc));
        end
      end
    end
  end

  // Memory-port monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd && mem_wr) fail_now("enable_overlap");
      else if (mem_rd || mem_wr) begin
        if (mop_q.size() == 0) fail_now("unexpected_mem_enable");
        else begin
          mop_t m;
          m = mop_q.pop_front();
          check("mem_we", WIDTH'(mem_wr), WIDTH'(m.we));
          check("mem_addr", WIDTH'(mem_addr), WIDTH'(m.addr));
          if (m.we) check("mem_wdata", mem_wdata, m.data);
        end
      end
    end
  end

  task automatic drive(input logic rid, input logic req, input logic we,
                       input logic [LOG_SIZE-1:0] addr, input logic [WIDTH-1:0] data);
    if (rid) begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = data;
    end else begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = data;
    end
  endtask

  task automatic wait_ack(input logic rid);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rid ? r1_ack : r0_ack) return;
    end
    fail_now(rid ? "engine_ack_timeout" : "host_ack_timeout");
  endtask

  // Single uncontended transaction, entered and left on a negedge with the DUT idle.
  task automatic solo(input logic rid, input logic we, input logic [LOG_SIZE-1:0] addr,
                      input logic [WIDTH-1:0] wdata, input logic exp_err,
                      input logic [WIDTH-1:0] exp_data, input int lat, input bit mutate);
    exp_t e;
    mop_t m;
    if (!exp_err) begin
      m = '{we: we, addr: addr, data: wdata};
      mop_q.push_back(m);
    end
    e = '{rid: rid, err: exp_err, chk_data: !we && !exp_err, data: exp_data, exp_cyc: cyc + lat};
    sb_q.push_back(e);
    drive(rid, 1'b1, we, addr, wdata);
    if (mutate) begin
      @(negedge clk);
      drive(rid, 1'b1, ~we, 10'h3FF, ~wdata);
    end
    wait_ack(rid);
    drive(rid, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  localparam logic [WIDTH-1:0] PAT   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [WIDTH-1:0] PAT_X = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [WIDTH-1:0] PAT_Y = 128'h5555000A_5555000B_5555000C_5555000D;

  task automatic push_exp(input logic rid, input logic chk, input logic [WIDTH-1:0] d);
    exp_t e;
    e = '{rid: rid, err: 1'b0, chk_data: chk, data: d, exp_cyc: -1};
    sb_q.push_back(e);
  endtask

  task automatic push_mop(input logic we, input logic [LOG_SIZE-1:0] a, input logic [WIDTH-1:0] d);
    mop_t m;
    m = '{we: we, addr: a, data: d};
    mop_q.push_back(m);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_read_en"}, WIDTH'(mem_rd), '0);
    check({tag, "_write_en"}, WIDTH'(mem_wr), '0);
    check({tag, "_acks"}, WIDTH'({r1_ack, r0_ack}), '0);
    check({tag, "_errs"}, WIDTH'({r1_err, r0_err}), '0);
    check({tag, "_mem_addr"}, WIDTH'(mem_addr), '0);
    check({tag, "_mem_data"}, mem_wdata, '0);
    check({tag, "_r0_data"}, r0_rdata, '0);
    check({tag, "_r1_data"}, r1_rdata, '0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    solo(R_HOST, 1'b1, 10'h004, PAT, 1'b0, '0, 3, 1'b0);
    solo(R_HOST, 1'b0, 10'h004, '0, 1'b0, PAT, 4, 1'b0);
    solo(R_ENGINE, 1'b0, 10'h3FC, '0, 1'b0,
         128'hC0DE03FF_C0DE03FE_C0DE03FD_C0DE03FC, 4, 1'b0);
    solo(R_ENGINE, 1'b0, 10'h3FD, '0, 1'b1, '0, 2, 1'b0);
    solo(R_ENGINE, 1'b0, 10'h008, '0, 1'b0,
         128'hC0DE000B_C0DE000A_C0DE0009_C0DE0008, 4, 1'b1);

    // Host read cut off by reset while the controller waits for read data.
    push_mop(1'b0, 10'h004, '0);
    drive(R_HOST, 1'b1, 1'b0, 10'h004, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(R_HOST, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    check_all_reset("midread_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held: the last pre-reset grant was host, so only the
    // reset of last_grant makes host win first here.
    push_exp(R_HOST, 1'b0, '0);      push_mop(1'b1, 10'h010, PAT_X);
    push_exp(R_ENGINE, 1'b0, '0);    push_mop(1'b1, 10'h020, PAT_Y);
    push_exp(R_HOST, 1'b1, PAT_Y);   push_mop(1'b0, 10'h020, '0);
    push_exp(R_ENGINE, 1'b1, PAT_X); push_mop(1'b0, 10'h010, '0);
    fork
      begin
        drive(R_HOST, 1'b1, 1'b1, 10'h010, PAT_X);
        wait_ack(R_HOST);
        drive(R_HOST, 1'b1, 1'b0, 10'h020, '0);
        wait_ack(R_HOST);
        drive(R_HOST, 1'b0, 1'b0, '0, '0);
      end
      begin
        drive(R_ENGINE, 1'b1, 1'b1, 10'h020, PAT_Y);
        wait_ack(R_ENGINE);
        drive(R_ENGINE, 1'b1, 1'b0, 10'h010, '0);
        wait_ack(R_ENGINE);
        drive(R_ENGINE, 1'b0, 1'b0, '0, '0);
      end
    join

    repeat (6) @(negedge clk);
    check("pending_acks", WIDTH'(sb_q.size()), '0);
    check("pending_mem_ops", WIDTH'(mop_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Two-port access controller in front of the coprocessor block memory (1024 x 32-bit cells, 4-cell block transfers, registered read data).
- Shares the single memory port between requester 0 (host) and requester 1 (engine).
- Arbitration is round-robin. Each granted request is sequenced into one read or write enable pulse, and each requester sees a req/ack handshake with out-of-range rejection.

Parameters:
size, 1024, memory depth in cells
blocks, 4, cells per transfer
log_size, 10, address width
cell_width, 32, bits per cell
width, blocks*cell_width, transfer width (128)

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous, active-low reset
in_r0_req  input  1  host request, level, held until ack
in_r0_we  input  1  host: 1 = write, 0 = read; valid with req
in_r0_address  input  log_size  host base cell address
in_r0_data  input  width  host write data
out_r0_ack  output  1  host completion, one-cycle pulse
out_r0_err  output  1  host out-of-range flag, valid with ack
out_r0_data  output  width  host read data, valid with ack
in_r1_req, in_r1_we, in_r1_address, in_r1_data, out_r1_ack, out_r1_err, out_r1_data  as above, for the engine
out_mem_address  output  log_size  memory in_address
out_mem_data  output  width  memory in_data
out_mem_read_en  output  1  memory in_read_en
out_mem_write_en  output  1  memory in_write_en
in_mem_data  input  width  memory out_data

Behaviour:
- All outputs are registered. Reset (asynchronous, any state, including mid-transaction) sets:
  - state = IDLE;
  - all acks, errs, enables = 0;
  - out_mem_address, out_mem_data, out_rN_data = 0;
  - last_grant = 1, so the host wins first.
- State IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the requester that is not last_grant.
  - Latch grant, we, address and data; set last_grant; go to CHECK.
- State CHECK (1 cycle):
  - If latched address > size - blocks: go to RESP with err = 1; memory is untouched.
  - Otherwise drive out_mem_address/out_mem_data and assert exactly one of read_en (we = 0) or write_en (we = 1); go to ISSUE.
- State ISSUE (1 cycle): enable stays high for exactly this cycle, and the memory samples at the end of it.
  - Write: go to RESP.
  - Read: go to WAIT.
- State WAIT (read only): drop read_en and capture in_mem_data into the granted requester's out_rN_data; go to RESP.
  - Capture happens only here, because in_mem_data is undefined or high-Z outside read cycles.
- State RESP: pulse out_rN_ack for the granted requester for 1 cycle, with err (0 or 1) as determined in CHECK; go to IDLE.
  - out_rN_data holds its value until that requester's next read.
- Latency, counted from the IDLE cycle in which req is sampled: write ack at +3, read ack at +4, error ack at +2.
- The requester drops req in the cycle after it sees ack. A req still high when IDLE is re-entered is treated as a new transaction.
- The non-granted requester waits with no ack. Its req inputs are ignored until IDLE.
- read_en and write_en are never high together and never high outside ISSUE.
- Under continuous contention, grants alternate 0,1,0,1; no starvation.
- Request inputs changing while a transaction is in flight have no effect, because values are latched in IDLE.
- Address 0 (config) and 1 (status) are ordinary addresses here; no protection.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encodings IDLE, CHECK, ISSUE, WAIT, RESP (3-bit);
  - requester indices R_HOST = 0, R_ENGINE = 1;
  - the out-of-range limit expression size - blocks.
- One natural sub-module: rr_arbiter2.
  - Combinational 2-way round-robin grant from req[1:0] and last_grant.
  - Instantiated once; the controller owns the registered last_grant.

Test Plan:
- Reset low mid-read (during WAIT) -> all enables and acks 0 immediately; after release, host req grants first (last_grant = 1).
- Host write: address 0x004, data 0x44444444_33333333_22222222_11111111 -> write_en high 1 cycle with address 0x004; ack at +3, err = 0.
- Host read back address 0x004 -> read_en high 1 cycle; ack at +4; out_r0_data = the written pattern.
- Both req in the same cycle, held for 4 back-to-back transactions -> grant order host, engine, host, engine; enables never overlap.
- Engine read at address 0x3FC -> accepted, data returned. Engine read at 0x3FD -> ack at +2 with err = 1, no read_en or write_en pulse.
- Engine changes in_r1_address during ISSUE -> memory sees the originally latched address.
